// File: rtl/core_load_check_ctrl_if.sv
// Bring-up bus for core_load_check_ctrl: program stream, imem write port,
// expected-value stream, core debug port and status. slave = controller side.
interface core_load_check_ctrl_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int REG_ID_W = 5,
  parameter int ERR_W    = 8
);
  logic                prog_valid;
  logic                prog_ready;
  logic [DATA_W-1:0]   prog_data;
  logic                prog_last;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                core_hold;
  logic                exp_valid;
  logic                exp_ready;
  logic [REG_ID_W-1:0] exp_id;
  logic [DATA_W-1:0]   exp_data;
  logic                exp_last;
  logic [REG_ID_W-1:0] reg_out_id;
  logic [DATA_W-1:0]   reg_out_data;
  logic                busy;
  logic                done;
  logic                pass;
  logic [1:0]          fail_code;
  logic [REG_ID_W-1:0] fail_id;
  logic [DATA_W-1:0]   fail_got;
  logic [ERR_W-1:0]    err_count;

  modport slave (
    input  prog_valid, prog_data, prog_last,
    input  exp_valid, exp_id, exp_data, exp_last,
    input  reg_out_data,
    output prog_ready, mem_we, mem_addr, mem_wdata, core_hold,
    output exp_ready, reg_out_id,
    output busy, done, pass, fail_code, fail_id, fail_got, err_count
  );

  modport master (
    output prog_valid, prog_data, prog_last,
    output exp_valid, exp_id, exp_data, exp_last,
    output reg_out_data,
    input  prog_ready, mem_we, mem_addr, mem_wdata, core_hold,
    input  exp_ready, reg_out_id,
    input  busy, done, pass, fail_code, fail_id, fail_got, err_count
  );
endinterface

// File: rtl/core_load_check_ctrl.sv
// Load/run/check bring-up controller for the single-cycle core.
// Define CHECK_CONTINUE_EN to keep checking after a register mismatch.
module core_load_check_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int REG_ID_W = 5,
  parameter int CYC_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  core_load_check_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHK_REQ, S_CHK_CMP, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CYC_W-1:0]    r_cnt;
  logic [REG_ID_W-1:0] r_reg_id;
  logic [DATA_W-1:0]   r_exp_data;
  logic                r_exp_last;
  logic                r_core_hold;
  logic                r_done;
  logic                r_pass;
  logic [1:0]          r_fail_code;
  logic [REG_ID_W-1:0] r_fail_id;
  logic [DATA_W-1:0]   r_fail_got;
  logic [ERR_W-1:0]    r_err_count;

  logic w_prog_acc;
  logic w_exp_acc;
  logic w_mismatch;
  logic w_stop;

  assign w_prog_acc = (r_state == S_LOAD) && bus.prog_valid;
  assign w_exp_acc  = (r_state == S_CHK_REQ) && bus.exp_valid;
  assign w_mismatch = (bus.reg_out_data != r_exp_data);
`ifdef CHECK_CONTINUE_EN
  assign w_stop = r_exp_last;
`else
  assign w_stop = r_exp_last || w_mismatch;
`endif

  assign bus.prog_ready = (r_state == S_LOAD);
  assign bus.mem_we     = w_prog_acc;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = bus.prog_data;
  assign bus.core_hold  = r_core_hold;
  assign bus.exp_ready  = (r_state == S_CHK_REQ);
  assign bus.reg_out_id = r_reg_id;
  assign bus.busy       = (r_state == S_LOAD) || (r_state == S_RUN) ||
                          (r_state == S_CHK_REQ) || (r_state == S_CHK_CMP);
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.fail_code  = r_fail_code;
  assign bus.fail_id    = r_fail_id;
  assign bus.fail_got   = r_fail_got;
  assign bus.err_count  = r_err_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_reg_id    <= '0;
      r_exp_data  <= '0;
      r_exp_last  <= 1'b0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= 2'd0;
      r_fail_id   <= '0;
      r_fail_got  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_addr      <= '0;
            r_err_count <= '0;
            r_fail_code <= 2'd0;
            r_fail_id   <= '0;
            r_fail_got  <= '0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_prog_acc) begin
            // Address saturates at the top word so it never wraps.
            if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_W'(1);
            if (bus.prog_last) begin
              r_state     <= S_RUN;
              r_cnt       <= (run_cycles == '0) ? CYC_W'(1) : run_cycles;
              r_core_hold <= 1'b0;
            end else if (r_addr == ADDR_MAX) begin
              r_state     <= S_DONE;
              r_fail_code <= 2'd2;
              r_pass      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CYC_W'(1);
          if (r_cnt == CYC_W'(1)) begin
            r_state     <= S_CHK_REQ;
            r_core_hold <= 1'b1;
          end
        end
        S_CHK_REQ: begin
          if (w_exp_acc) begin
            r_state    <= S_CHK_CMP;
            r_reg_id   <= bus.exp_id;
            r_exp_data <= bus.exp_data;
            r_exp_last <= bus.exp_last;
          end
        end
        S_CHK_CMP: begin
          if (w_mismatch) begin
            if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_W'(1);
            if (r_fail_code == 2'd0) begin
              r_fail_code <= 2'd1;
              r_fail_id   <= r_reg_id;
              r_fail_got  <= bus.reg_out_data;
            end
          end
          if (w_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_fail_code == 2'd0);
          end else begin
            r_state <= S_CHK_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_load_check_ctrl.sv
// Bench for core_load_check_ctrl: directed table plus randomized vectors
// checked against a pair-by-pair reference model with a frozen register file.
module tb_core_load_check_ctrl;
  localparam int AW = 2;
`ifdef CHECK_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] run_cycles;
  logic [31:0] regs [32];
  int          n_checks = 0;
  int          n_errors = 0;

  core_load_check_ctrl_if #(.ADDR_W(AW)) bus ();

  core_load_check_ctrl #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .bus        (bus)
  );

  always #5 clock = ~clock;
  assign bus.reg_out_data = regs[bus.reg_out_id];

  typedef struct {
    int          n_prog;
    logic [31:0] prog [4];
    bit          has_last;
    int          rc;
    int          n_exp;
    logic [4:0]  eid [4];
    logic [31:0] edat [4];
    bit          thr;
    bit          xstart;
    bit          e_pass;
    int          e_code;
    int          e_fid;
    logic [31:0] e_got;
    int          e_err;
    int          e_cons;
    int          e_writes;
    int          e_run;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk1(input logic [31:0] w, input int rc, input logic [4:0] id,
                               input logic [31:0] d, input bit thr, input bit xs,
                               input bit p, input int code, input int fid,
                               input logic [31:0] got, input int err);
    vec_t v;
    v.n_prog = 1; v.prog[0] = w; v.prog[1] = '0; v.prog[2] = '0; v.prog[3] = '0;
    v.has_last = 1'b1; v.rc = rc; v.n_exp = 1;
    for (int i = 0; i < 4; i++) begin v.eid[i] = id; v.edat[i] = d; end
    v.thr = thr; v.xstart = xs;
    v.e_pass = p; v.e_code = code; v.e_fid = fid; v.e_got = got; v.e_err = err;
    v.e_cons = 1; v.e_writes = 1; v.e_run = (rc == 0) ? 1 : rc;
    return v;
  endfunction

  // Reference: the core runs max(rc,1) cycles; pairs are consumed in order
  // until the last one, or the first mismatch when not continuing.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit stop = 1'b0;
    bit mis;
    r.e_fid = 0; r.e_got = '0; r.e_err = 0; r.e_cons = 0;
    if (!v.has_last) begin
      r.e_writes = 4; r.e_run = 0; r.e_code = 2; r.e_pass = 1'b0;
      return r;
    end
    r.e_writes = v.n_prog;
    r.e_run = (v.rc == 0) ? 1 : v.rc;
    for (int i = 0; i < v.n_exp && !stop; i++) begin
      r.e_cons++;
      mis = (regs[v.eid[i]] != v.edat[i]);
      if (mis) begin
        if (r.e_err == 0) begin r.e_fid = int'(v.eid[i]); r.e_got = regs[v.eid[i]]; end
        r.e_err++;
      end
      stop = (i == v.n_exp - 1) || (mis && !CONT);
    end
    r.e_code = (r.e_err > 0) ? 1 : 0;
    r.e_pass = (r.e_err == 0);
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int pi = 0, ei = 0, nrun = 0, cyc = 0;
    bit fin = 1'b0;
    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    run_cycles = 16'(v.rc);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!fin && cyc < 400) begin
      if (bus.done) begin
        fin = 1'b1;
      end else begin
        start = v.xstart && (cyc == 2);
        bus.prog_valid = (pi < v.n_prog) && !(v.thr && (cyc % 2 == 0));
        bus.prog_data  = v.prog[pi % 4];
        bus.prog_last  = v.has_last && (pi == v.n_prog - 1);
        bus.exp_valid  = (ei < v.n_exp) && !(v.thr && (cyc % 2 == 0));
        bus.exp_id     = v.eid[ei % 4];
        bus.exp_data   = v.edat[ei % 4];
        bus.exp_last   = (ei == v.n_exp - 1);
        #1;
        if (bus.mem_we) begin wa.push_back(bus.mem_addr); wd.push_back(bus.mem_wdata); end
        if (bus.prog_valid && bus.prog_ready) pi++;
        if (bus.exp_valid && bus.exp_ready) ei++;
        if (!bus.core_hold) nrun++;
        cyc++;
        @(negedge clock);
      end
    end
    start = 1'b0; bus.prog_valid = 1'b0; bus.exp_valid = 1'b0;
    chk({tag, " finished"}, 64'(fin), 64'd1);
    chk({tag, " writes"}, 64'(wa.size()), 64'(v.e_writes));
    for (int i = 0; i < wa.size() && i < v.e_writes; i++) begin
      chk({tag, " waddr"}, 64'(wa[i]), 64'(i));
      chk({tag, " wdata"}, 64'(wd[i]), 64'(v.prog[i]));
    end
    chk({tag, " run_cycles"}, 64'(nrun), 64'(v.e_run));
    chk({tag, " consumed"}, 64'(ei), 64'(v.e_cons));
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " core_hold"}, 64'(bus.core_hold), 64'd1);
    chk({tag, " exp_ready"}, 64'(bus.exp_ready), 64'd0);
    chk({tag, " pass"}, 64'(bus.pass), 64'(v.e_pass));
    chk({tag, " fail_code"}, 64'(bus.fail_code), 64'(v.e_code));
    chk({tag, " fail_id"}, 64'(bus.fail_id), 64'(v.e_fid));
    chk({tag, " fail_got"}, 64'(bus.fail_got), 64'(v.e_got));
    chk({tag, " err_count"}, 64'(bus.err_count), 64'(v.e_err));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " core_hold"}, 64'(bus.core_hold), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
    chk({tag, " pass"}, 64'(bus.pass), 64'd0);
    chk({tag, " mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, " prog_ready"}, 64'(bus.prog_ready), 64'd0);
    chk({tag, " status"}, {bus.fail_code, bus.fail_id, bus.err_count, bus.reg_out_id},
        64'd0);
    chk({tag, " fail_got"}, 64'(bus.fail_got), 64'd0);
  endtask

  vec_t tbl [6];
  vec_t rv;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1111_0000 + 32'(i);
    regs[0] = 32'd0; regs[10] = 32'd3;
    reset = 1'b1; start = 1'b1; run_cycles = 16'd5;
    bus.prog_valid = 1'b1; bus.prog_data = 32'h0030_0513; bus.prog_last = 1'b1;
    bus.exp_valid = 1'b0; bus.exp_id = '0; bus.exp_data = '0; bus.exp_last = 1'b0;

    tbl[0] = mk1(32'h0030_0513, 5, 5'd10, 32'd3, 1'b0, 1'b0, 1'b1, 0, 0, 32'd0, 0);
    tbl[1] = mk1(32'h0030_0513, 5, 5'd10, 32'd4, 1'b0, 1'b0, 1'b0, 1, 10, 32'd3, 1);
    tbl[2] = mk1(32'h0030_0513, 5, 5'd10, 32'd3, 1'b0, 1'b0, 1'b0, 2, 0, 32'd0, 0);
    tbl[2].n_prog = 4; tbl[2].has_last = 1'b0; tbl[2].e_cons = 0;
    tbl[2].e_writes = 4; tbl[2].e_run = 0;
    for (int i = 0; i < 4; i++) tbl[2].prog[i] = 32'hA5A5_0000 + 32'(i);
    tbl[3] = mk1(32'h0030_0513, 5, 5'd10, 32'd9, 1'b0, 1'b0, 1'b0, 1, 10, 32'd3, 1);
    tbl[3].n_exp = 3;
    tbl[3].eid[1] = 5'd0;  tbl[3].edat[1] = 32'd0;
    tbl[3].eid[2] = 5'd10; tbl[3].edat[2] = 32'd7;
    tbl[3].e_err  = CONT ? 2 : 1;
    tbl[3].e_cons = CONT ? 3 : 1;
    tbl[4] = mk1(32'h0030_0513, 5, 5'd10, 32'd3, 1'b1, 1'b1, 1'b1, 0, 0, 32'd0, 0);
    tbl[5] = mk1(32'h0050_0593, 0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0, 0, 32'd0, 0);

    repeat (3) @(negedge clock);
    reset = 1'b0; start = 1'b0; bus.prog_valid = 1'b0;
    @(negedge clock);
    check_idle("reset");

    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset two cycles into a five-cycle run.
    run_cycles = 16'd5;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    bus.prog_valid = 1'b1; bus.prog_data = 32'h0030_0513; bus.prog_last = 1'b1;
    @(negedge clock); bus.prog_valid = 1'b0;
    chk("run1 core_hold", 64'(bus.core_hold), 64'd0);
    @(negedge clock);
    chk("run2 core_hold", 64'(bus.core_hold), 64'd0);
    reset = 1'b1; start = 1'b1; bus.prog_valid = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0; bus.prog_valid = 1'b0;
    check_idle("midreset");
    apply(tbl[0], "after_reset");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
      rv = tbl[0];
      rv.has_last = ($urandom_range(0, 4) != 0);
      rv.n_prog = rv.has_last ? $urandom_range(1, 4) : 4;
      for (int i = 0; i < 4; i++) rv.prog[i] = $urandom;
      rv.rc = $urandom_range(0, 12);
      rv.n_exp = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        rv.eid[i] = 5'($urandom_range(0, 31));
        rv.edat[i] = ($urandom_range(0, 2) != 0) ? regs[rv.eid[i]] : $urandom;
      end
      rv.thr = 1'($urandom_range(0, 1));
      rv.xstart = 1'($urandom_range(0, 1));
      rv = model(rv);
      apply(rv, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
